// File: rtl/alu_pkg.sv
// Shared definitions for the alu_mdu execute unit: op codes, FSM encoding and op-class helpers.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Codes 16..23 form the M-extension block: bit 2 selects divide, bit 1 remainder.
  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_mul(input logic [4:0] op);
    return is_muldiv(op) && !op[2];
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return is_muldiv(op) && op[2];
  endfunction

  function automatic logic is_rem(input logic [4:0] op);
    return is_div(op) && op[1];
  endfunction

  function automatic logic is_signed_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative radix-2 multiply/divide datapath: shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up folded into the final-iteration result.
module mdu_iter_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  logic            active;
  logic [SHW-1:0]  cnt;
  logic [4:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] hi_q, lo_q, m_q;

  logic            a_sgn, b_sgn, a_neg, b_neg, neg_d;
  logic [XLEN-1:0] a_mag, b_mag;

  logic [XLEN:0]     add_sum, rem_sh, diff;
  logic [XLEN-1:0]   hi_n, lo_n, quo, rem;
  logic [2*XLEN-1:0] prod;

  // Operand conditioning: both multiply and divide run on unsigned magnitudes.
  always_comb begin
    a_sgn = (op == OP_MULH) || (op == OP_MULHSU) || is_signed_div(op);
    b_sgn = (op == OP_MULH) || is_signed_div(op);
    a_neg = a_sgn & a[XLEN-1];
    b_neg = b_sgn & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    // Remainder follows the dividend's sign; everything else the sign product.
    neg_d = is_rem(op) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    add_sum = {1'b0, hi_q} + {1'b0, m_q};
    rem_sh  = {hi_q, lo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, m_q};
    if (is_mul(op_q)) begin
      if (lo_q[0]) {hi_n, lo_n} = {add_sum, lo_q[XLEN-1:1]};
      else         {hi_n, lo_n} = {1'b0, hi_q, lo_q[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      hi_n = diff[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_n = rem_sh[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], 1'b0};
    end

    prod = {hi_n, lo_n};
    if (neg_q) prod = -prod;
    quo = neg_q ? -lo_n : lo_n;
    rem = neg_q ? -hi_n : hi_n;

    case (op_q)
      OP_MUL:                       res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res = quo;
      default:                      res = rem;
    endcase
  end

  assign done = active && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= SHW'(XLEN - 1);
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

  // Datapath registers carry no reset; they are always loaded on start.
  always_ff @(posedge clk) begin
    if (start) begin
      op_q  <= op;
      neg_q <= neg_d;
      hi_q  <= '0;
      lo_q  <= a_mag;
      m_q   <= b_mag;
    end else if (active) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// RV32I ALU plus RV32M multiply/divide execute unit with valid/ready handshakes.
// Optional ALU_MDU_FAST_MUL_EN: single-cycle combinational multiply instead of iterative.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less
);

  state_t state, state_nx;

  logic            accept, one_cycle, core_start, core_done, load_res, ov_d;
  logic [XLEN-1:0] core_res, alu_res, res_d;
  logic            b_zero, div_ovf, sc_hit, fast_hit;
  logic [XLEN-1:0] sc_res, fast_res;

  logic signed [XLEN-1:0] a_s, b_s;
  logic [SHW-1:0]         shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[SHW-1:0];

  always_comb begin
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, a_s < b_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = a_s >>> shamt;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      default: alu_res = '0;
    endcase
  end

  // Divide corner cases resolve without iterating.
  always_comb begin
    b_zero  = (b == '0);
    div_ovf = is_signed_div(op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    sc_hit  = is_div(op) && (b_zero || div_ovf);
    if (b_zero) sc_res = is_rem(op) ? a : '1;
    else        sc_res = is_rem(op) ? '0 : a;
  end

`ifdef ALU_MDU_FAST_MUL_EN
  logic              a_top, b_top;
  logic [2*XLEN-1:0] ax, bx, fprod;

  always_comb begin
    a_top    = ((op == OP_MULH) || (op == OP_MULHSU)) & a[XLEN-1];
    b_top    = (op == OP_MULH) & b[XLEN-1];
    ax       = {{XLEN{a_top}}, a};
    bx       = {{XLEN{b_top}}, b};
    fprod    = ax * bx;
    fast_hit = is_mul(op);
    fast_res = (op == OP_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
  end
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // A new op may enter while the previous result is being consumed.
  assign in_ready  = (state != BUSY) && (!out_valid || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign one_cycle = !is_muldiv(op) || sc_hit || fast_hit;

  always_comb begin
    state_nx   = state;
    ov_d       = out_valid;
    load_res   = 1'b0;
    core_start = 1'b0;
    res_d      = alu_res;
    case (state)
      IDLE, DONE: begin
        if (out_valid && out_ready) begin
          ov_d     = 1'b0;
          state_nx = IDLE;
        end
        if (accept) begin
          if (one_cycle) begin
            load_res = 1'b1;
            ov_d     = 1'b1;
            state_nx = DONE;
            if (sc_hit)        res_d = sc_res;
            else if (fast_hit) res_d = fast_res;
          end else begin
            core_start = 1'b1;
            state_nx   = BUSY;
          end
        end
      end
      BUSY: begin
        if (core_done) begin
          load_res = 1'b1;
          ov_d     = 1'b1;
          res_d    = core_res;
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx   = IDLE;
      ov_d       = 1'b0;
      load_res   = 1'b0;
      core_start = 1'b0;
    end
  end

  mdu_iter_core #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .start (core_start),
    .op    (op),
    .a     (a),
    .b     (b),
    .done  (core_done),
    .res   (core_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      less      <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= ov_d;
      if (load_res) begin
        result <= res_d;
        zero   <= (res_d == '0);
        less   <= res_d[XLEN-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed testbench for alu_mdu: ALU ops, multiply, divide, backpressure, flush and reset.
`timescale 1ns/1ps
module tb_alu_mdu;
  import alu_pkg::*;

`ifdef ALU_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, zero, less;
  logic [4:0]  op;
  logic [31:0] a, b, result;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .less      (less)
  );

  // Issue one op with out_ready high, scramble inputs after accept, return result and latency.
  task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic z, output logic l, output int lat);
    int w;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'd9; a = $urandom; b = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    r = result; z = zero; l = less;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if ({zero, less} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {zero, less}); end
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_alu();
    logic [4:0]  ops [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd31};
    logic [31:0] ta  [12] = '{32'h7FFFFFFF, 32'd5, 32'd1, 32'hFFFFFFFF, 32'd1, 32'hF0F0F0F0,
                              32'h80000000, 32'h80000000, 32'h12340000, 32'hFFFF0000, 32'd5, 32'd1};
    logic [31:0] tb  [12] = '{32'd1, 32'd5, 32'd33, 32'd1, 32'hFFFFFFFF, 32'hFF00FF00,
                              32'h24, 32'h24, 32'h00005678, 32'h0F0F0F0F, 32'd5, 32'd1};
    logic [31:0] te  [12] = '{32'h80000000, 32'h0, 32'd2, 32'd1, 32'd1, 32'h0FF00FF0,
                              32'h08000000, 32'hF8000000, 32'h12345678, 32'h0F0F0000, 32'h0, 32'h0};
    logic [31:0] r;
    logic z, l;
    int lat;
    for (int i = 0; i < 12; i++) begin
      do_op(ops[i], ta[i], tb[i], r, z, l, lat);
      total++; if (r !== te[i]) begin bad++; $display("FAIL alu_result[%0d] got=%h want=%h", i, r, te[i]); end
      total++; if (lat !== 1) begin bad++; $display("FAIL alu_latency[%0d] got=%0d want=1", i, lat); end
      total++; if (z !== (te[i] == 32'h0)) begin bad++; $display("FAIL alu_zero[%0d] got=%b want=%b", i, z, te[i] == 32'h0); end
      total++; if (l !== te[i][31]) begin bad++; $display("FAIL alu_less[%0d] got=%b want=%b", i, l, te[i][31]); end
    end
  endtask

  task automatic test_mul();
    logic [4:0]  ops [6] = '{OP_MULH, OP_MULHU, OP_MUL, OP_MULHSU, OP_MULHU, OP_MULH};
    logic [31:0] ta  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] tb  [6] = '{32'd2, 32'd2, 32'd3, 32'd2, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] te  [6] = '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h40000000};
    logic [31:0] r;
    logic z, l;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], ta[i], tb[i], r, z, l, lat);
      total++; if (r !== te[i]) begin bad++; $display("FAIL mul_result[%0d] got=%h want=%h", i, r, te[i]); end
      total++; if (lat !== MUL_LAT) begin bad++; $display("FAIL mul_latency[%0d] got=%0d want=%0d", i, lat, MUL_LAT); end
    end
    do_op(OP_MUL, 32'h00012345, 32'd100, r, z, l, lat);
    total++; if (r !== 32'h0071C6F4) begin bad++; $display("FAIL mul_small got=%h want=0071c6f4", r); end
  endtask

  task automatic test_div();
    logic [4:0]  ops [12] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM,
                              OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_DIVU};
    logic [31:0] ta  [12] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000, 32'h80000000,
                              32'd100, 32'd100, 32'd7, 32'd7, 32'd0, 32'hFFFFFFFF};
    logic [31:0] tb  [12] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd1};
    logic [31:0] te  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0,
                              32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    int          tl  [12] = '{33, 33, 1, 1, 1, 1, 33, 33, 33, 33, 1, 33};
    logic [31:0] r;
    logic z, l;
    int lat;
    for (int i = 0; i < 12; i++) begin
      do_op(ops[i], ta[i], tb[i], r, z, l, lat);
      total++; if (r !== te[i]) begin bad++; $display("FAIL div_result[%0d] got=%h want=%h", i, r, te[i]); end
      total++; if (lat !== tl[i]) begin bad++; $display("FAIL div_latency[%0d] got=%0d want=%0d", i, lat, tl[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    @(negedge clk);
    out_ready = 1'b0; op = OP_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 100) begin @(negedge clk); w++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (result !== 32'd3 || out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d] got=%h/%b want=00000003/1", i, result, out_valid);
      end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready); end
    end
    @(negedge clk);
    out_ready = 1'b1; op = OP_ADD; a = 32'd4; b = 32'd4; in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || result !== 32'd8) begin
      bad++; $display("FAIL b2b_result got=%h/%b want=00000008/1", result, out_valid);
    end
  endtask

  task automatic test_flush();
    logic seen;
    @(negedge clk);
    op = OP_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_after got=%b want=1", in_ready); end
    seen = out_valid;
    repeat (40) begin @(negedge clk); seen = seen | out_valid; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_valid got=%b want=0", seen); end
    total++; if (result !== 32'd8) begin bad++; $display("FAIL flush_result_kept got=%h want=00000008", result); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic z, l, seen;
    int lat;
    @(negedge clk);
    op = OP_DIV; a = 32'hFFFFFFF9; b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; op = OP_ADD; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b0 || less !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs got=%b/%h/%b/%b want=0/00000000/0/0", out_valid, result, zero, less);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen = seen | out_valid; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_no_valid got=%b want=0", seen); end
    do_op(OP_ADD, 32'd2, 32'd3, r, z, l, lat);
    total++; if (r !== 32'd5) begin bad++; $display("FAIL midreset_add got=%h want=00000005", r); end
    total++; if (lat !== 1) begin bad++; $display("FAIL midreset_add_lat got=%0d want=1", lat); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
